vend_controller: RTL and testbench
==================================

# vend_controller

Sequencing controller for the coin-accumulator datapath of the vending machine. It edge-detects the 100/500 coin inputs, accumulates credit up to a ceiling, rejects coins it cannot accept, and handles product selection, dispensing and unit-by-unit change return. An optional inactivity timeout triggers an automatic refund. It sits between the coin/button front panel and the dispense/change actuators; `credit` feeds the existing 7-segment display decoder.

## Interface
- `BITS`, 4 — credit width.
- `MAX_CREDIT`, 10 — highest credit value accepted; must be < 2^BITS.
- `PRICE_A`, 3 — price of product A in 100-units; must satisfy 1..MAX_CREDIT.
- `PRICE_B`, 7 — price of product B in 100-units; must satisfy 1..MAX_CREDIT.
- `TIMEOUT`, 15 — inactivity cycles before auto-refund.

- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `moneda100`  in  1  — level input from the 100 coin; a rising edge adds 1.
- `moneda500`  in  1  — level input from the 500 coin; a rising edge adds 5.
- `sel_a`, `sel_b`  in  1 each  — product select, level-sampled.
- `cancel`  in  1  — request full refund, level-sampled.
- `credit`  out  BITS  — current credit.
- `dispense_a`, `dispense_b`  out  1 each  — one-cycle dispense strobe.
- `change_pulse`  out  1  — one-cycle strobe per 100-unit returned.
- `coin_reject`  out  1  — one-cycle strobe when a coin edge is refused.
- `short_funds`  out  1  — one-cycle strobe when a selection is made with credit below the price.
- `busy`  out  1  — high in DISPENSE or CHANGE.

## Operation
- **Coin edge detection**
  - Registered previous values of both coin inputs; these reset to 0.
  - An edge is `moneda & ~prev`.
  - An input held high through reset release counts as one edge.
- **States**
  - IDLE: credit == 0.
  - COLLECT: credit > 0.
  - DISPENSE.
  - CHANGE.
- **IDLE/COLLECT event priority:** cancel > select > coin.
  - **Cancel** in COLLECT → CHANGE. Cancel in IDLE is ignored.
  - **Select** (sel_a wins over sel_b):
    - If credit ≥ price: debit credit by the price, latch the product, → DISPENSE.
    - Otherwise: strobe `short_funds`, stay in the current state.
  - **Coins:**
    - 100 accepted if credit+1 ≤ MAX_CREDIT.
    - 500 accepted if credit+5 ≤ MAX_CREDIT.
    - Sums are computed at BITS+1 width. A refused coin strobes `coin_reject`.
    - Simultaneous 100 and 500 edges: process 100 only; reject 500.
    - A coin edge arriving in the same cycle as an accepted cancel or select is rejected.
    - An accepted coin in IDLE → COLLECT.
- **DISPENSE:** exactly one cycle with `dispense_a` or `dispense_b` high. Then → CHANGE if credit > 0, else → IDLE.
- **CHANGE:**
  - Alternates pulse and gap cycles, starting with a pulse.
  - Each pulse cycle: `change_pulse` = 1, and credit decrements at the edge that ends the cycle.
  - After the pulse that brings credit to 0 → IDLE, with no trailing gap.
- **Coin edges in DISPENSE/CHANGE** are rejected; selects and cancel are ignored.
- **Reset:**
  - State = IDLE, credit = 0, all strobes 0, `busy` = 0, timeout counter = 0.
  - Reset is honoured in any state, including mid-CHANGE. Undelivered change is discarded.

## Timing
- Inputs are sampled at edge k; credit and state update at edge k.
- Strobes (`coin_reject`, `short_funds`) are registered and high for the cycle after edge k.
- A select accepted at edge k: `dispense_x` is high in cycle k+1, and the state leaves DISPENSE at edge k+2.
- Refund of N units:
  - Pulses occur in CHANGE cycles 0, 2, …, 2N−2.
  - IDLE is reached 2N−1 cycles after entering CHANGE.
- `busy` is decoded from the registered state.
- The timeout counter has width clog2(TIMEOUT+1) and saturates.

## Configuration
- **`VEND_TIMEOUT_EN` defined:**
  - In COLLECT, the counter increments each cycle with no accepted coin.
  - It clears on an accepted coin and on leaving COLLECT.
  - On reaching TIMEOUT, the state → CHANGE at that edge.
- **`VEND_TIMEOUT_EN` undefined:** no counter is built, and COLLECT holds indefinitely.

## Test plan
1. 500 edge, then `sel_a`:
   - `credit` = 5.
   - `dispense_a` is high one cycle and `credit` = 2.
   - Two `change_pulse` strobes occur 2 cycles apart.
   - End state: IDLE, `credit` = 0.
2. Two 500 edges, then a 100 edge:
   - `credit` = 10.
   - The 100 coin strobes `coin_reject` once and `credit` stays 10.
3. `credit` = 5, `sel_b`:
   - `short_funds` is high one cycle.
   - The state stays COLLECT with `credit` = 5, and `busy` = 0.
4. Simultaneous 100/500 rising edges from `credit` = 0:
   - `credit` = 1, `coin_reject` high one cycle, state COLLECT.
5. `credit` = 3, idle with macro defined:
   - After 15 cycles the state enters CHANGE.
   - Three pulses occur and the state reaches IDLE 5 cycles later.
   - With the macro undefined, `credit` stays 3 for 100 cycles.
6. `rst` low during the second change pulse:
   - At the next edge: IDLE, `credit` = 0, `change_pulse` = 0.
   - No further pulses after `rst` returns high.

Source files
------------

// File: rtl/vend_controller.sv
// vend_controller: coin-credit vending sequencer with change return, optional auto-refund under VEND_TIMEOUT_EN
module vend_controller #(
  parameter int BITS       = 4,
  parameter int MAX_CREDIT = 10,
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 7,
  parameter int TIMEOUT    = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            moneda100,
  input  logic            moneda500,
  input  logic            sel_a,
  input  logic            sel_b,
  input  logic            cancel,
  output logic [BITS-1:0] credit,
  output logic            dispense_a,
  output logic            dispense_b,
  output logic            change_pulse,
  output logic            coin_reject,
  output logic            short_funds,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;
  state_t state, state_nxt;
  logic [BITS-1:0] credit_nxt;
  logic [BITS:0] wide, price;
  logic prev100, prev500, e100, e500;
  logic prod, prod_nxt, gap, gap_nxt, reject_nxt, short_nxt;
  logic open, cancel_ok, sel, sel_ok, c100_ok, c500_ok, coin_ok, timeout;
  if (MAX_CREDIT >= 2**BITS || PRICE_A < 1 || PRICE_A > MAX_CREDIT ||
      PRICE_B < 1 || PRICE_B > MAX_CREDIT || TIMEOUT < 1) begin : g_bad_params
    $error("vend_controller: illegal parameter set");
  end
  assign e100 = moneda100 & ~prev100;
  assign e500 = moneda500 & ~prev500;
  always_comb begin
    open       = state == IDLE || state == COLLECT;
    wide       = {1'b0, credit};
    price      = sel_a ? (BITS+1)'(PRICE_A) : (BITS+1)'(PRICE_B);
    cancel_ok  = state == COLLECT && cancel;
    sel        = open && !cancel_ok && (sel_a || sel_b);
    sel_ok     = sel && wide >= price;
    c100_ok    = open && !cancel_ok && !sel_ok && e100 &&
                 wide + (BITS+1)'(1) <= (BITS+1)'(MAX_CREDIT);
    c500_ok    = open && !cancel_ok && !sel_ok && !e100 && e500 &&
                 wide + (BITS+1)'(5) <= (BITS+1)'(MAX_CREDIT);
    coin_ok    = c100_ok || c500_ok;
    reject_nxt = (e100 && !c100_ok) || (e500 && !c500_ok);
    short_nxt  = sel && !sel_ok;
  end
`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign timeout = state == COLLECT && !cancel_ok && !sel_ok && !coin_ok &&
                   tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst)
      tcnt <= '0;
    else
      tcnt <= (state == COLLECT && state_nxt == COLLECT && !coin_ok) ?
              (tcnt == TW'(TIMEOUT) ? tcnt : tcnt + TW'(1)) : '0;
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= '0;
      prev100     <= 1'b0;
      prev500     <= 1'b0;
      prod        <= 1'b0;
      gap         <= 1'b0;
      coin_reject <= 1'b0;
      short_funds <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      prev100     <= moneda100;
      prev500     <= moneda500;
      prod        <= prod_nxt;
      gap         <= gap_nxt;
      coin_reject <= reject_nxt;
      short_funds <= short_nxt;
    end
  end
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    prod_nxt   = prod;
    case (state)
      IDLE, COLLECT: begin
        if (cancel_ok) begin
          state_nxt = CHANGE;
        end else if (sel_ok) begin
          credit_nxt = credit - BITS'(price);
          prod_nxt   = !sel_a;
          state_nxt  = DISPENSE;
        end else if (coin_ok) begin
          credit_nxt = credit + (c100_ok ? BITS'(1) : BITS'(5));
          state_nxt  = COLLECT;
        end else if (timeout) begin
          state_nxt = CHANGE;
        end
      end
      DISPENSE: state_nxt = credit != '0 ? CHANGE : IDLE;
      default: begin
        if (!gap) begin
          credit_nxt = credit - BITS'(1);
          state_nxt  = credit == BITS'(1) ? IDLE : CHANGE;
        end
      end
    endcase
    gap_nxt = state == CHANGE && state_nxt == CHANGE && !gap;
  end
  always_comb begin
    dispense_a   = state == DISPENSE && !prod;
    dispense_b   = state == DISPENSE && prod;
    change_pulse = state == CHANGE && !gap;
    busy         = state == DISPENSE || state == CHANGE;
  end
endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed stimulus with a cycle model and literal checks for vend_controller
module tb_vend_controller;
  localparam int BITS = 4, MAXC = 10, PA = 3, PB = 7;
`ifdef VEND_TIMEOUT_EN
  localparam int TMO = 15;
`endif
  logic clk = 0, rst = 0, moneda100 = 0, moneda500 = 0, sel_a = 0, sel_b = 0, cancel = 0;
  logic [BITS-1:0] credit;
  logic dispense_a, dispense_b, change_pulse, coin_reject, short_funds, busy;
  int checks = 0, failures = 0;
  bit started = 0;
  int m_credit = 0, m_ref = -1, m_idle = 0;
  bit m_disp = 0, m_prod = 0, m_p100 = 0, m_p500 = 0, m_rej = 0, m_short = 0;

  vend_controller dut (
    .clk(clk), .rst(rst), .moneda100(moneda100), .moneda500(moneda500),
    .sel_a(sel_a), .sel_b(sel_b), .cancel(cancel), .credit(credit),
    .dispense_a(dispense_a), .dispense_b(dispense_b), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .short_funds(short_funds), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin : model
    bit e100, e500, acc;
    int price;
`ifdef VEND_TIMEOUT_EN
    bit wc;
    wc = !m_disp && m_ref < 0 && m_credit > 0;
`endif
    e100 = moneda100 && !m_p100;
    e500 = moneda500 && !m_p500;
    m_p100 = moneda100;
    m_p500 = moneda500;
    acc = 0;
    price = sel_a ? PA : PB;
    if (!rst) begin
      m_credit = 0; m_ref = -1; m_idle = 0; m_disp = 0; m_prod = 0;
      m_rej = 0; m_short = 0; m_p100 = 0; m_p500 = 0;
    end else begin
      m_rej = 0;
      m_short = 0;
      if (m_disp) begin
        m_disp = 0;
        m_rej = e100 || e500;
        if (m_credit > 0) m_ref = 0;
      end else if (m_ref >= 0) begin
        m_rej = e100 || e500;
        if (m_ref % 2 == 0) begin
          m_credit--;
          m_ref = (m_credit == 0) ? -1 : m_ref + 1;
        end else m_ref++;
      end else if (cancel && m_credit > 0) begin
        m_ref = 0;
        m_rej = e100 || e500;
      end else if ((sel_a || sel_b) && m_credit >= price) begin
        m_credit -= price;
        m_prod = !sel_a;
        m_disp = 1;
        m_rej = e100 || e500;
      end else begin
        m_short = sel_a || sel_b;
        if (e100) begin
          if (m_credit + 1 <= MAXC) begin m_credit++; acc = 1; end
          else m_rej = 1;
          if (e500) m_rej = 1;
        end else if (e500) begin
          if (m_credit + 5 <= MAXC) begin m_credit += 5; acc = 1; end
          else m_rej = 1;
        end
      end
`ifdef VEND_TIMEOUT_EN
      m_idle = (wc && !m_disp && m_ref < 0 && !acc) ? m_idle + 1 : 0;
      if (m_idle == TMO) begin m_ref = 0; m_idle = 0; end
`endif
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("credit", 32'(credit), 32'(m_credit));
      chk("dispense_a", 32'(dispense_a), 32'(m_disp && !m_prod));
      chk("dispense_b", 32'(dispense_b), 32'(m_disp && m_prod));
      chk("change_pulse", 32'(change_pulse), 32'(m_ref >= 0 && m_ref % 2 == 0));
      chk("busy", 32'(busy), 32'(m_disp || m_ref >= 0));
      chk("coin_reject", 32'(coin_reject), 32'(m_rej));
      chk("short_funds", 32'(short_funds), 32'(m_short));
    end
  end

  initial begin
    rst = 0;
    step();
    started = 1;
    step();
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_change", 32'(change_pulse), 0);
    moneda100 = 1; step();
    rst = 1; step();
    chk("held_edge_credit", 32'(credit), 1);
    moneda100 = 0; cancel = 1; step();
    cancel = 0;
    chk("refund1_pulse", 32'(change_pulse), 1);
    step();
    chk("refund1_idle", 32'(credit), 0);
    chk("refund1_busy", 32'(busy), 0);
    moneda500 = 1; step();
    chk("t1_credit5", 32'(credit), 5);
    moneda500 = 0; sel_a = 1; step();
    sel_a = 0;
    chk("t1_dispense_a", 32'(dispense_a), 1);
    chk("t1_credit2", 32'(credit), 2);
    step();
    chk("t1_pulse1", 32'(change_pulse), 1);
    step();
    chk("t1_gap", 32'(change_pulse), 0);
    step();
    chk("t1_pulse2", 32'(change_pulse), 1);
    step();
    chk("t1_end_credit", 32'(credit), 0);
    chk("t1_end_busy", 32'(busy), 0);
    repeat (2) begin moneda500 = 1; step(); moneda500 = 0; step(); end
    chk("t2_credit10", 32'(credit), 10);
    moneda100 = 1; step();
    chk("t2_reject", 32'(coin_reject), 1);
    chk("t2_credit_hold", 32'(credit), 10);
    moneda100 = 0; step();
    chk("t2_reject_off", 32'(coin_reject), 0);
    cancel = 1; step();
    cancel = 0; moneda100 = 1; step();
    chk("t2_change_coin_reject", 32'(coin_reject), 1);
    moneda100 = 0;
    repeat (20) step();
    chk("t2_refund_done", 32'(credit), 0);
    sel_b = 1; step();
    sel_b = 0;
    chk("idle_sel_short", 32'(short_funds), 1);
    moneda500 = 1; step();
    moneda500 = 0; sel_b = 1; step();
    sel_b = 0;
    chk("t3_short", 32'(short_funds), 1);
    chk("t3_credit", 32'(credit), 5);
    chk("t3_busy", 32'(busy), 0);
    step();
    chk("t3_short_off", 32'(short_funds), 0);
    cancel = 1; step();
    cancel = 0;
    repeat (10) step();
    chk("t3_refund_done", 32'(credit), 0);
    moneda100 = 1; moneda500 = 1; step();
    chk("t4_credit1", 32'(credit), 1);
    chk("t4_reject", 32'(coin_reject), 1);
    chk("t4_busy", 32'(busy), 0);
    moneda100 = 0; moneda500 = 0; step();
    chk("t4_reject_off", 32'(coin_reject), 0);
    repeat (2) begin moneda100 = 1; step(); moneda100 = 0; step(); end
`ifdef VEND_TIMEOUT_EN
    repeat (13) step();
    chk("t5_before_timeout", 32'(busy), 0);
    chk("t5_credit3", 32'(credit), 3);
    step();
    chk("t5_timeout_busy", 32'(busy), 1);
    chk("t5_timeout_pulse", 32'(change_pulse), 1);
    repeat (5) step();
    chk("t5_idle_credit", 32'(credit), 0);
    chk("t5_idle_busy", 32'(busy), 0);
`else
    repeat (100) step();
    chk("t5_hold_credit3", 32'(credit), 3);
    chk("t5_hold_busy", 32'(busy), 0);
    cancel = 1; step();
    cancel = 0;
    repeat (6) step();
    chk("t5_refund_done", 32'(credit), 0);
`endif
    moneda500 = 1; step();
    moneda500 = 0; cancel = 1; step();
    cancel = 0;
    chk("t6_pulse1", 32'(change_pulse), 1);
    step();
    step();
    chk("t6_pulse2", 32'(change_pulse), 1);
    chk("t6_credit4", 32'(credit), 4);
    rst = 0; step();
    chk("t6_rst_credit", 32'(credit), 0);
    chk("t6_rst_pulse", 32'(change_pulse), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    rst = 1;
    repeat (10) begin
      step();
      chk("t6_no_pulse", 32'(change_pulse), 0);
    end
    chk("t6_final_credit", 32'(credit), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
